sio_target: RTL and testbench

- Remote end of the sio half-duplex link.
- Receives a 22-bit command frame from the host on the shared data line and decodes it into a register-write strobe.
- Then drives back 192 scrambled sample bits (8 channels × 24 bits) followed by a 16-bit readback word.
- Sits in the remote IO FPGA; the IO buffer is external (sdi/sdo/sdo_oe), and the clock is frequency-locked to the host's 125 MHz.

---
 rtl/sio_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_sio_target.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sio_target.sv
// sio_target: remote end of the sio half-duplex link.
// Receives a 22-bit command frame on sdi and decodes it into a register-write strobe.
// It then drives 192 scrambled sample bits and a 16-bit readback word back on sdo.
module sio_target #(
  parameter int unsigned CYC_PER_BIT = 2,
  parameter int unsigned TURN_BITS   = 8,
  parameter int unsigned GUARD_BITS  = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         sdi,
  output logic         sdo,
  output logic         sdo_oe,
  input  logic [191:0] sample_data,
  output logic         sample_strobe,
  input  logic [15:0]  resp_data,
  output logic         cmd_valid,
  output logic [3:0]   cmd_addr,
  output logic [15:0]  cmd_data,
  output logic         frame_err
);

  localparam int unsigned PhW = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam logic [PhW-1:0] PhLast    = PhW'(CYC_PER_BIT - 1);
  localparam logic [21:0]    LfsrSeed  = 22'h3FFFFF;
  localparam logic [7:0]     CmdLast   = 8'd19;
  localparam logic [7:0]     TurnLast  = 8'(TURN_BITS - 1);
  localparam logic [7:0]     SampLast  = 8'd191;
  localparam logic [7:0]     RespLast  = 8'd15;
  localparam logic [7:0]     GuardLast = 8'(GUARD_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart2,
    StCmd,
    StTurn,
    StSamples,
    StResp,
    StRelease
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d, phase_base;
  logic [21:0]      lfsr_q, lfsr_d, lfsr_step;
  logic [7:0]       cnt_q, cnt_d, nk;
  logic [18:0]      shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             reseed_q, reseed_d;
  logic [7:0][23:0] samples_q;
  logic [15:0]      resp_q;
  logic             samples_load, resp_load;
  logic             start_det, tick;
  logic [2:0]       ch_idx;
  logic [4:0]       bit_idx;
  logic             smp_bit;

  logic             sdo_q, sdo_d;
  logic             sdo_oe_q, sdo_oe_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [3:0]       cmd_addr_q, cmd_addr_d;
  logic [15:0]      cmd_data_q, cmd_data_d;
  logic             sample_strobe_q, sample_strobe_d;
  logic             frame_err_q, frame_err_d;

  // A start bit realigns the bit clock so that the detection cycle is itself a sample point.
  assign start_det = (state_q == StIdle) && armed_q && !sdi;
  assign tick      = (phase_q == '0) || start_det;
  assign lfsr_step = {lfsr_q[20:0], lfsr_q[21] ^ lfsr_q[0]};

  // Next sample bit: channel 7 first, channels interleaved, MSB first within a channel.
  assign nk      = cnt_q + 8'd1;
  assign ch_idx  = 3'd7 - nk[2:0];
  assign bit_idx = 5'd23 - nk[7:3];
  assign smp_bit = samples_q[ch_idx][bit_idx];

  // Free-running bit-phase counter with realignment on start detection.
  always_comb begin
    phase_base = start_det ? '0 : phase_q;
    phase_d    = (phase_base == PhLast) ? '0 : phase_base + PhW'(1);
  end

  // Frame FSM: next state, shift/count registers and registered output values.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    armed_d         = armed_q;
    reseed_d        = reseed_q;
    lfsr_d          = tick ? lfsr_step : lfsr_q;
    sdo_d           = sdo_q;
    sdo_oe_d        = sdo_oe_q;
    cmd_valid_d     = 1'b0;
    cmd_addr_d      = cmd_addr_q;
    cmd_data_d      = cmd_data_q;
    sample_strobe_d = 1'b0;
    frame_err_d     = frame_err_q;
    samples_load    = 1'b0;
    resp_load       = 1'b0;

    case (state_q)
      StIdle: begin
        // Require a high line before accepting a start bit.
        if (sdi) armed_d = 1'b1;
        if (start_det) begin
          state_d = StStart2;
          armed_d = 1'b0;
        end
      end
      StStart2: begin
        if (tick) begin
          if (sdi) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
      end
      StCmd: begin
        if (tick) begin
          shift_d = {shift_q[17:0], sdi};
          if (cnt_q == CmdLast) begin
            cmd_addr_d      = shift_q[18:15];
            cmd_data_d      = {shift_q[14:0], sdi};
            cmd_valid_d     = (shift_q[18:15] != 4'hF);
            sample_strobe_d = 1'b1;
            samples_load    = 1'b1;
            if (shift_q[18:15] == 4'h4) reseed_d = 1'b1;
            state_d = StTurn;
            cnt_d   = '0;
          end else begin
            cnt_d = nk;
          end
        end
      end
      StTurn: begin
        if (tick) begin
          if (cnt_q == TurnLast) begin
            if (reseed_q) begin
              lfsr_d   = LfsrSeed;
              reseed_d = 1'b0;
            end
            sdo_oe_d = 1'b1;
            // Driven bit is scrambled with the LFSR state held while it is on the wire.
            sdo_d    = samples_q[7][23] ^ lfsr_d[21];
            state_d  = StSamples;
            cnt_d    = '0;
          end else begin
            cnt_d = nk;
          end
        end
      end
      StSamples: begin
        if (tick) begin
          if (cnt_q == SampLast) begin
            resp_load = 1'b1;
            sdo_d     = resp_data[15];
            state_d   = StResp;
            cnt_d     = '0;
          end else begin
            sdo_d = smp_bit ^ lfsr_d[21];
            cnt_d = nk;
          end
        end
      end
      StResp: begin
        if (tick) begin
          if (cnt_q == RespLast) begin
            sdo_oe_d = 1'b0;
            sdo_d    = 1'b1;
            state_d  = StRelease;
            cnt_d    = '0;
          end else begin
            sdo_d = resp_q[4'd14 - cnt_q[3:0]];
            cnt_d = nk;
          end
        end
      end
      StRelease: begin
        if (tick) begin
          if (cnt_q == GuardLast) begin
            state_d = StIdle;
            armed_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = nk;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops sdo_oe immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      phase_q         <= '0;
      lfsr_q          <= LfsrSeed;
      cnt_q           <= '0;
      shift_q         <= '0;
      armed_q         <= 1'b0;
      reseed_q        <= 1'b0;
      samples_q       <= '0;
      resp_q          <= '0;
      sdo_q           <= 1'b1;
      sdo_oe_q        <= 1'b0;
      cmd_valid_q     <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_data_q      <= '0;
      sample_strobe_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      lfsr_q          <= lfsr_d;
      cnt_q           <= cnt_d;
      shift_q         <= shift_d;
      armed_q         <= armed_d;
      reseed_q        <= reseed_d;
      if (samples_load) samples_q <= sample_data;
      if (resp_load)    resp_q    <= resp_data;
      sdo_q           <= sdo_d;
      sdo_oe_q        <= sdo_oe_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_data_q      <= cmd_data_d;
      sample_strobe_q <= sample_strobe_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign sdo           = sdo_q;
  assign sdo_oe        = sdo_oe_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_data      = cmd_data_q;
  assign sample_strobe = sample_strobe_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_sio_target.sv
// Self-checking bench for sio_target: host-side frame driver, wire capture and stream model.
module tb_sio_target;

  localparam int CYC    = 2;
  localparam int TURN   = 8;
  localparam int GUARD  = 4;
  localparam int BUDGET = 800;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         sdi;
  logic         sdo;
  logic         sdo_oe;
  logic [191:0] sample_data;
  logic         sample_strobe;
  logic [15:0]  resp_data;
  logic         cmd_valid;
  logic [3:0]   cmd_addr;
  logic [15:0]  cmd_data;
  logic         frame_err;

  int total = 0;
  int bad   = 0;

  sio_target #(
    .CYC_PER_BIT(CYC),
    .TURN_BITS  (TURN),
    .GUARD_BITS (GUARD)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sdi          (sdi),
    .sdo          (sdo),
    .sdo_oe       (sdo_oe),
    .sample_data  (sample_data),
    .sample_strobe(sample_strobe),
    .resp_data    (resp_data),
    .cmd_valid    (cmd_valid),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .frame_err    (frame_err)
  );

  always #4 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected wire stream: 192 scrambled sample bits from a fresh seed, then the readback word.
  function automatic logic [207:0] model_stream(input logic [191:0] smp, input logic [15:0] resp);
    logic [21:0]  s;
    logic [207:0] st;
    s  = 22'h3FFFFF;
    st = '0;
    for (int k = 0; k < 192; k++) begin
      st[207-k] = smp[24*(7 - k%8) + 23 - k/8] ^ s[21];
      s = {s[20:0], s[21] ^ s[0]};
    end
    st[15:0] = resp;
    return st;
  endfunction

  task automatic check_reset_values(input string pfx);
    check({pfx, "_sdo"},    32'(sdo), 32'd1);
    check({pfx, "_sdo_oe"}, 32'(sdo_oe), 32'd0);
    check({pfx, "_valid"},  32'(cmd_valid), 32'd0);
    check({pfx, "_addr"},   32'(cmd_addr), 32'd0);
    check({pfx, "_data"},   32'(cmd_data), 32'd0);
    check({pfx, "_strobe"}, 32'(sample_strobe), 32'd0);
    check({pfx, "_ferr"},   32'(frame_err), 32'd0);
  endtask

  // Drives one host frame and checks everything the target does in response.
  // abort_bit >= 0 asserts reset while that sample bit is on the wire.
  task automatic run_frame(input logic [3:0] addr, input logic [15:0] data,
                           input logic [191:0] smp, input logic [15:0] resp,
                           input int abort_bit, input logic err_exp,
                           output logic [207:0] cap);
    logic [21:0]  fr;
    logic [207:0] expv;
    int idle, nv, ns, strobe_cyc, oe_start, oe_len, ncap, done_cyc;
    bit aborted;
    fr          = {2'b00, addr, data};
    idle        = 3 + int'($urandom_range(0, 3));
    sample_data = smp;
    resp_data   = resp;
    nv = 0; ns = 0; strobe_cyc = -1000; oe_start = -1; oe_len = 0; ncap = 0; done_cyc = -1;
    aborted = 0;
    cap = '0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clock);
      #1;
      if (i >= idle && i < idle + 22*CYC) sdi = fr[21 - (i - idle)/CYC];
      else sdi = 1'b1;
      @(negedge clock);
      if (cmd_valid) begin
        nv++;
        check("valid_addr", 32'(cmd_addr), 32'(addr));
        check("valid_data", 32'(cmd_data), 32'(data));
        check("strobe_with_valid", 32'(sample_strobe), 32'd1);
      end
      if (sample_strobe) begin
        ns++;
        strobe_cyc = i;
      end
      if (sdo_oe) begin
        if (oe_start < 0) oe_start = i;
        oe_len++;
        if ((i - oe_start) % CYC == 0 && ncap < 208) begin
          cap[207-ncap] = sdo;
          ncap++;
          if (abort_bit >= 0 && ncap == abort_bit + 1) begin
            reset_n = 1'b0;
            #1;
            check_reset_values("abort");
            aborted = 1;
            break;
          end
        end
      end else if (oe_start >= 0 && done_cyc < 0) begin
        done_cyc = i;
      end
      if (done_cyc >= 0 && i >= done_cyc + GUARD*CYC + 4) break;
    end
    if (aborted) begin
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_values("in_reset");
      reset_n = 1'b1;
    end else begin
      check("frame_done", 32'(done_cyc >= 0), 32'd1);
      check("valid_count", 32'(nv), 32'(addr != 4'hF));
      check("strobe_count", 32'(ns), 32'd1);
      check("turn_gap", 32'(oe_start - strobe_cyc), 32'(TURN*CYC));
      check("oe_width", 32'(oe_len), 32'(208*CYC));
      check("resp_bits", 32'(cap[15:0]), 32'(resp));
      if (addr == 4'h4) begin
        expv = model_stream(smp, resp);
        for (int c = 0; c < 6; c++)
          check($sformatf("stream%0d", c), cap[207-32*c -: 32], expv[207-32*c -: 32]);
      end
      check("cmd_addr_hold", 32'(cmd_addr), 32'(addr));
      check("cmd_data_hold", 32'(cmd_data), 32'(data));
      check("frame_err", 32'(frame_err), 32'(err_exp));
      check("idle_sdo", 32'(sdo), 32'd1);
    end
  endtask

  // One low bit followed by a high second start bit.
  task automatic run_glitch();
    int  nv;
    bit  oe_seen;
    nv = 0;
    oe_seen = 0;
    for (int i = 0; i < 40*CYC; i++) begin
      @(posedge clock);
      #1;
      sdi = (i >= 4 && i < 4 + CYC) ? 1'b0 : 1'b1;
      @(negedge clock);
      if (cmd_valid) nv++;
      if (sdo_oe) oe_seen = 1;
    end
    check("glitch_ferr", 32'(frame_err), 32'd1);
    check("glitch_valid", 32'(nv), 32'd0);
    check("glitch_oe", 32'(oe_seen), 32'd0);
  endtask

  function automatic logic [191:0] rand_smp();
    logic [191:0] v;
    for (int w = 0; w < 6; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [207:0] cap;
    logic [191:0] smp;
    logic [3:0]   a;
    reset_n     = 1'b0;
    sdi         = 1'b1;
    sample_data = '0;
    resp_data   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_values("post_reset");

    // Plain write.
    run_frame(4'h3, 16'hA55A, rand_smp(), 16'($urandom), -1, 1'b0, cap);
    // No-op frame.
    run_frame(4'hF, 16'hFFFF, rand_smp(), 16'($urandom), -1, 1'b0, cap);
    // Reseed with zero samples: wire carries the raw PRN sequence.
    run_frame(4'h4, 16'($urandom), '0, 16'h1234, -1, 1'b0, cap);
    check("prn22", 32'(cap[207:186]), 32'h3FFFFF);
    check("resp_1234", 32'(cap[15:0]), 32'h1234);
    // Ordering: only ch7 MSB set, so only driven bit 0 descrambles to 1.
    smp = '0;
    smp[191:168] = 24'h800000;
    run_frame(4'h4, 16'($urandom), smp, 16'($urandom), -1, 1'b0, cap);
    check("order_bit0", 32'(cap[207]), 32'd0);
    // Glitch, then a normal frame with the sticky error still set.
    run_glitch();
    run_frame(4'h7, 16'($urandom), rand_smp(), 16'($urandom), -1, 1'b1, cap);
    // Reset during the sample burst, then a clean frame.
    run_frame(4'h2, 16'($urandom), rand_smp(), 16'($urandom), 100, 1'b1, cap);
    run_frame(4'h4, 16'($urandom), rand_smp(), 16'($urandom), -1, 1'b0, cap);

    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 4'h4;
        1:       a = 4'hF;
        default: a = 4'($urandom);
      endcase
      run_frame(a, 16'($urandom), rand_smp(), 16'($urandom), -1, 1'b0, cap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
